// File: rtl/multi_channel_accumulator_if.sv
// Purpose : bundle of control, status and snapshot signals between a harness
//           and the multi-channel accumulator.
// Ports   : master = harness (drives en/inc/clear/load/snap_req/snap_ready),
//           slave  = accumulator (drives count/overflow/tick/snap_*).
`timescale 1ns/1ps
interface multi_channel_accumulator_if #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int INC_WIDTH  = 8,
  parameter int TICK_WIDTH = 8
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Per-channel controls; channel i occupies slice [i*INC_WIDTH +: INC_WIDTH].
  logic [CHANNELS-1:0]           en;
  logic [CHANNELS*INC_WIDTH-1:0] inc;
  logic                          clear;
  logic                          load;
  logic [SEL_W-1:0]              load_sel;
  logic [WIDTH-1:0]              load_val;

  // Live status; channel i at [i*WIDTH +: WIDTH].
  logic [CHANNELS*WIDTH-1:0]     count;
  logic [CHANNELS-1:0]           overflow;
  logic [TICK_WIDTH-1:0]         tick;

  // Snapshot handshake.
  logic                          snap_req;
  logic                          snap_valid;
  logic                          snap_ready;
  logic [CHANNELS*WIDTH-1:0]     snap_data;
  logic [TICK_WIDTH-1:0]         snap_tick;

  modport master (
    output en, inc, clear, load, load_sel, load_val, snap_req, snap_ready,
    input  count, overflow, tick, snap_valid, snap_data, snap_tick
  );

  modport slave (
    input  en, inc, clear, load, load_sel, load_val, snap_req, snap_ready,
    output count, overflow, tick, snap_valid, snap_data, snap_tick
  );
endinterface

// File: rtl/multi_channel_accumulator.sv
// Purpose : CHANNELS independent accumulators with wrap/saturate arithmetic,
//           sticky overflow, per-channel load, global clear, free-running tick
//           and a one-deep snapshot register with valid/ready handshake.
// Latency : every update is visible on the outputs one edge after it is applied;
//           all outputs are registered.
// Backpr. : a snapshot waits for snap_ready; requests arriving while one is
//           held un-accepted are dropped, never queued.
// Ports   : clock (rising edge), reset (async active-low), acc_if (slave modport).
`timescale 1ns/1ps
module multi_channel_accumulator #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int INC_WIDTH  = 8,
  parameter int SATURATE   = 0,
  parameter int TICK_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  multi_channel_accumulator_if.slave  acc_if
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [WIDTH-1:0] cnt_t;

  // Accumulator state.
  cnt_t [CHANNELS-1:0]        count_q, count_d;
  logic [CHANNELS-1:0]        ovf_q, ovf_d;
  logic [TICK_WIDTH-1:0]      tick_q;

  // Snapshot state.
  logic                       snap_vld_q, snap_vld_d;
  cnt_t [CHANNELS-1:0]        snap_dat_q, snap_dat_d;
  logic [TICK_WIDTH-1:0]      snap_tick_q, snap_tick_d;
  logic                       snap_accept;

  // Per-channel sum one bit wider than the accumulator; the top bit is the carry.
  logic [CHANNELS-1:0][WIDTH:0] sum;
  logic [CHANNELS-1:0]          load_hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign sum[g] = {1'b0, count_q[g]}
                  + (WIDTH+1)'(acc_if.inc[g*INC_WIDTH +: INC_WIDTH]);
    // load_sel values >= CHANNELS never match any channel, so they are no-ops.
    assign load_hit[g] = acc_if.load && (acc_if.load_sel == SEL_W'(g));
  end

  // Channel next-state: clear > load > increment > hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (acc_if.clear) begin
        count_d[i] = '0;
        ovf_d[i]   = 1'b0;
      end else if (load_hit[i]) begin
        // A load also discards any same-cycle increment and restarts overflow.
        count_d[i] = acc_if.load_val;
        ovf_d[i]   = 1'b0;
      end else if (acc_if.en[i]) begin
        if (sum[i][WIDTH]) begin
          // A saturated channel re-carries on any nonzero increment, so it
          // stays pinned at all-ones without extra state.
          count_d[i] = (SATURATE != 0) ? '1 : sum[i][WIDTH-1:0];
          ovf_d[i]   = 1'b1;
        end else begin
          count_d[i] = sum[i][WIDTH-1:0];
        end
      end
    end
  end

  // Snapshot: a slot is free when empty or being drained this cycle. The
  // captured values are the pre-update count/tick of the accepting edge.
  always_comb begin
    snap_accept = acc_if.snap_req && (!snap_vld_q || acc_if.snap_ready);
    snap_vld_d  = snap_vld_q;
    snap_dat_d  = snap_dat_q;
    snap_tick_d = snap_tick_q;
    if (snap_accept) begin
      snap_vld_d  = 1'b1;
      snap_dat_d  = count_q;
      snap_tick_d = tick_q;
    end else if (acc_if.snap_ready) begin
      snap_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      ovf_q       <= '0;
      tick_q      <= '0;
      snap_vld_q  <= 1'b0;
      snap_dat_q  <= '0;
      snap_tick_q <= '0;
    end else begin
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      tick_q      <= tick_q + TICK_WIDTH'(1);
      snap_vld_q  <= snap_vld_d;
      snap_dat_q  <= snap_dat_d;
      snap_tick_q <= snap_tick_d;
    end
  end

  assign acc_if.count      = count_q;
  assign acc_if.overflow   = ovf_q;
  assign acc_if.tick       = tick_q;
  assign acc_if.snap_valid = snap_vld_q;
  assign acc_if.snap_data  = snap_dat_q;
  assign acc_if.snap_tick  = snap_tick_q;

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Purpose : drives a 4-channel wrap instance and a 3-channel saturate instance
//           from shared stimulus and compares both against an arithmetic model.
// Latency : inputs change on the falling edge, outputs are sampled on the
//           following falling edge (one rising edge later).
// Backpr. : snap_ready is driven by the bench, directed and random.
`timescale 1ns/1ps
module tb_multi_channel_accumulator;
  logic clock;
  logic reset;

  // Shared stimulus (sized for 4 channels; the 3-channel instance takes the low part).
  logic [3:0]  en;
  logic [31:0] inc;
  logic        clear;
  logic        load;
  logic [1:0]  load_sel;
  logic [7:0]  load_val;
  logic        snap_req;
  logic        snap_ready;

  int n_tests;
  int n_fail;

  multi_channel_accumulator_if #(.CHANNELS(4), .WIDTH(8), .INC_WIDTH(8), .TICK_WIDTH(8)) w_if ();
  multi_channel_accumulator_if #(.CHANNELS(3), .WIDTH(8), .INC_WIDTH(8), .TICK_WIDTH(8)) s_if ();

  assign w_if.en = en;           assign s_if.en = en[2:0];
  assign w_if.inc = inc;         assign s_if.inc = inc[23:0];
  assign w_if.clear = clear;     assign s_if.clear = clear;
  assign w_if.load = load;       assign s_if.load = load;
  assign w_if.load_sel = load_sel; assign s_if.load_sel = load_sel;
  assign w_if.load_val = load_val; assign s_if.load_val = load_val;
  assign w_if.snap_req = snap_req; assign s_if.snap_req = snap_req;
  assign w_if.snap_ready = snap_ready; assign s_if.snap_ready = snap_ready;

  multi_channel_accumulator #(.CHANNELS(4), .WIDTH(8), .INC_WIDTH(8), .SATURATE(0), .TICK_WIDTH(8))
    u_wrap (.clock(clock), .reset(reset), .acc_if(w_if));
  multi_channel_accumulator #(.CHANNELS(3), .WIDTH(8), .INC_WIDTH(8), .SATURATE(1), .TICK_WIDTH(8))
    u_sat  (.clock(clock), .reset(reset), .acc_if(s_if));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: index 0 = wrap/4 channels, index 1 = saturate/3 channels.
  int m_cnt [2][4];
  bit m_ov  [2][4];
  bit m_sv  [2];
  int m_sd  [2][4];
  int m_st  [2];
  int m_tick;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sv[k] = 1'b0;
      m_st[k] = 0;
      for (int c = 0; c < 4; c++) begin
        m_cnt[k][c] = 0; m_ov[k][c] = 1'b0; m_sd[k][c] = 0;
      end
    end
    m_tick = 0;
  endtask

  task automatic model_step();
    int n;
    int t;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (snap_req && (!m_sv[k] || snap_ready)) begin
        m_sv[k] = 1'b1;
        m_st[k] = m_tick;
        for (int c = 0; c < 4; c++) m_sd[k][c] = m_cnt[k][c];
      end else if (snap_ready) begin
        m_sv[k] = 1'b0;
      end
      for (int c = 0; c < n; c++) begin
        if (clear) begin
          m_cnt[k][c] = 0; m_ov[k][c] = 1'b0;
        end else if (load && int'(load_sel) == c) begin
          m_cnt[k][c] = int'(load_val); m_ov[k][c] = 1'b0;
        end else if (en[c]) begin
          t = m_cnt[k][c] + int'(inc[c*8 +: 8]);
          if (t > 255) begin
            m_ov[k][c]  = 1'b1;
            m_cnt[k][c] = (k == 1) ? 255 : t - 256;
          end else begin
            m_cnt[k][c] = t;
          end
        end
      end
    end
    m_tick = (m_tick + 1) % 256;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ec, esd;
    logic [3:0]  eo;
    for (int k = 0; k < 2; k++) begin
      ec = '0; esd = '0; eo = '0;
      for (int c = 0; c < ((k == 0) ? 4 : 3); c++) begin
        ec[c*8 +: 8]  = 8'(m_cnt[k][c]);
        esd[c*8 +: 8] = 8'(m_sd[k][c]);
        eo[c]         = m_ov[k][c];
      end
      if (k == 0) begin
        check_eq({tag, "_w_cnt"},   64'(w_if.count),      64'(ec));
        check_eq({tag, "_w_ovf"},   64'(w_if.overflow),   64'(eo));
        check_eq({tag, "_w_svld"},  64'(w_if.snap_valid), 64'(m_sv[k]));
        check_eq({tag, "_w_sdat"},  64'(w_if.snap_data),  64'(esd));
        check_eq({tag, "_w_stick"}, 64'(w_if.snap_tick),  64'(m_st[k]));
        check_eq({tag, "_tick"},    64'(w_if.tick),       64'(m_tick));
      end else begin
        check_eq({tag, "_s_cnt"},   64'(s_if.count),      64'(ec));
        check_eq({tag, "_s_ovf"},   64'(s_if.overflow),   64'(eo));
        check_eq({tag, "_s_svld"},  64'(s_if.snap_valid), 64'(m_sv[k]));
        check_eq({tag, "_s_sdat"},  64'(s_if.snap_data),  64'(esd));
        check_eq({tag, "_s_stick"}, 64'(s_if.snap_tick),  64'(m_st[k]));
      end
    end
  endtask

  // One rising edge: model follows the inputs that were stable across it.
  task automatic cycle(input string tag);
    @(posedge clock);
    if (reset) model_step();
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic set_idle();
    en = '0; inc = '0; clear = 1'b0; load = 1'b0; load_sel = '0; load_val = '0;
    snap_req = 1'b0; snap_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    set_idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    check_eq("reset_tick_const", 64'(w_if.tick), 64'd0);
    reset = 1'b1;

    // Long run with wrap-around: 300 increments of 1.
    en = 4'hF; inc = 32'h01010101;
    repeat (300) cycle("wrap300");
    check_eq("wrap300_cnt_const",  64'(w_if.count),    64'h2C2C2C2C);
    check_eq("wrap300_ovf_const",  64'(w_if.overflow), 64'hF);
    check_eq("wrap300_tick_const", 64'(w_if.tick),     64'd44);
    check_eq("sat300_cnt_const",   64'(s_if.count),    64'hFFFFFF);

    // Saturation on channel 2.
    set_idle(); clear = 1'b1; cycle("sat_clr");
    clear = 1'b0; load = 1'b1; load_sel = 2'd2; load_val = 8'd250; cycle("sat_ld");
    load = 1'b0; en = 4'b0100; inc = 32'h00030000;
    cycle("sat_i1"); check_eq("sat_i1_const", 64'(s_if.count), 64'hFD0000);
    check_eq("sat_i1_ovf_const", 64'(s_if.overflow), 64'h0);
    cycle("sat_i2"); check_eq("sat_i2_const", 64'(s_if.count), 64'hFF0000);
    check_eq("sat_i2_ovf_const", 64'(s_if.overflow), 64'h4);
    cycle("sat_i3"); check_eq("sat_i3_const", 64'(s_if.count), 64'hFF0000);

    // Clear beats a simultaneous load, with overflows set beforehand.
    en = 4'hF; inc = 32'hF0F0F0F0;
    repeat (2) cycle("pre_clr");
    clear = 1'b1; load = 1'b1; load_sel = 2'd1; load_val = 8'h10;
    cycle("clr_ld");
    check_eq("clr_ld_w_const", 64'(w_if.count), 64'h0);
    check_eq("clr_ld_s_const", 64'(s_if.count), 64'h0);
    check_eq("clr_ld_ovf_const", 64'(w_if.overflow), 64'h0);

    // load_sel=3 is out of range for the 3-channel instance.
    set_idle(); en = 4'hF; inc = 32'h01010101; load = 1'b1; load_sel = 2'd3; load_val = 8'hAA;
    cycle("oor_ld");
    check_eq("oor_s_const", 64'(s_if.count), 64'h010101);
    check_eq("oor_w_const", 64'(w_if.count), 64'hAA010101);

    // Snapshot hold with backpressure; realign tick with a reset pulse first.
    set_idle();
    reset = 1'b0; model_reset();
    @(negedge clock);
    reset = 1'b1;
    load = 1'b1;
    for (int c = 0; c < 4; c++) begin
      load_sel = 2'(c); load_val = 8'(c + 1);
      cycle("snap_ld");
    end
    load = 1'b0;
    repeat (3) cycle("snap_idle");
    snap_req = 1'b1;
    cycle("snap_acc");
    check_eq("snap_tick_const", 64'(w_if.snap_tick), 64'd7);
    check_eq("snap_w_dat_const", 64'(w_if.snap_data), 64'h04030201);
    check_eq("snap_s_dat_const", 64'(s_if.snap_data), 64'h030201);
    snap_req = 1'b0; en = 4'hF; inc = 32'h01010101;
    for (int i = 0; i < 5; i++) begin
      snap_req = (i == 2);
      cycle("snap_hold");
      check_eq("snap_hold_dat_const",  64'(w_if.snap_data),  64'h04030201);
      check_eq("snap_hold_tick_const", 64'(w_if.snap_tick),  64'd7);
      check_eq("snap_hold_vld_const",  64'(w_if.snap_valid), 64'd1);
    end
    snap_req = 1'b0; snap_ready = 1'b1;
    cycle("snap_drain");
    check_eq("snap_drain_vld_const", 64'(w_if.snap_valid), 64'd0);
    snap_ready = 1'b0;

    // Asynchronous reset between edges.
    repeat (3) cycle("pre_arst");
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("arst");
    check_eq("arst_cnt_const", 64'(w_if.count), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) cycle("post_arst");
    check_eq("post_arst_const", 64'(w_if.count), 64'h03030303);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      en = 4'($urandom);
      for (int c = 0; c < 4; c++)
        inc[c*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      clear      = ($urandom_range(0, 31) == 0);
      load       = ($urandom_range(0, 9) == 0);
      load_sel   = 2'($urandom);
      load_val   = 8'($urandom);
      snap_req   = ($urandom_range(0, 2) == 0);
      snap_ready = ($urandom_range(0, 1) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
